// File: rtl/paddle_ctrl_if.sv
// Signal bundle between one paddle controller and the video/game logic.
// Master = video timing and player/game side, slave = paddle_ctrl.
interface paddle_ctrl_if;
  // There is no valid/ready handshake on this bundle. Every input is a level
  // that is sampled on each clk. The only event is the rising edge of vblank,
  // which starts one frame update. Every output is registered and valid on
  // every cycle.
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [10:0] hpos;
  logic        up;
  logic        down;
  logic        vblank;
  logic        auto_mode;
  logic [10:0] ball_v_pos;
  logic [10:0] paddle_v_pos;
  logic        pixel_valid;
  logic        moving;
  logic [1:0]  fsm_state;

  modport master (
    output hcount, vcount, hpos, up, down, vblank, auto_mode, ball_v_pos,
    input  paddle_v_pos, pixel_valid, moving, fsm_state
  );

  modport slave (
    input  hcount, vcount, hpos, up, down, vblank, auto_mode, ball_v_pos,
    output paddle_v_pos, pixel_valid, moving, fsm_state
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle controller: moves once per frame on vblank rise, accelerates while held, clamps at limits.
// Optional computer control is compiled in with the PADDLE_AUTO_EN macro.
module paddle_ctrl #(
  parameter int PADDLE_WIDTH  = 8,
  parameter int PADDLE_HEIGHT = 40,
  parameter int TOP_LIMIT     = 20,
  parameter int BOTTOM_LIMIT  = 460,
  parameter int INIT_POS      = 220,
  parameter int MAX_SPEED     = 8,
  parameter int ACCEL_FRAMES  = 4,
  parameter int AUTO_DEADBAND = 4
) (
  input logic          clk,
  input logic          rst,
  paddle_ctrl_if.slave pif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [11:0] TOP12    = 12'(TOP_LIMIT);
  localparam logic [11:0] BOT12    = 12'(BOTTOM_LIMIT);
  localparam logic [11:0] H12      = 12'(PADDLE_HEIGHT);
  localparam logic [11:0] W12      = 12'(PADDLE_WIDTH);
  localparam logic [10:0] INIT11   = 11'(INIT_POS);
  localparam logic [3:0]  MAX_SPD  = 4'(MAX_SPEED);
  localparam logic [7:0]  ACC_LAST = 8'(ACCEL_FRAMES - 1);

  state_t      state_q, state_d;
  logic [3:0]  speed_q, speed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] pos_q, pos_d;
  logic        vblank_q;
  logic        vb_seen_q;
  logic        pv_q, pv_d;
  logic        moving_q;

  logic        tick;
  logic        req_up, req_dn;
  logic        man_up, man_dn;
  logic [3:0]  step;
  logic        do_up, do_dn;
  logic [3:0]  stay_speed;
  logic [7:0]  stay_cnt;
  logic [11:0] pos12, step12;
  logic [10:0] up_pos, dn_pos;

  // vblank_q only holds a real sample after the first clock out of reset, so
  // vblank already high at reset release cannot be taken as a rising edge.
  assign tick = pif.vblank & ~vblank_q & vb_seen_q;

  assign man_up = pif.up & ~pif.down;
  assign man_dn = pif.down & ~pif.up;

`ifdef PADDLE_AUTO_EN
  logic [11:0] center12, ball12;
  logic        auto_up, auto_dn;

  assign center12 = pos12 + 12'(PADDLE_HEIGHT / 2);
  assign ball12   = {1'b0, pif.ball_v_pos};
  assign auto_up  = (ball12 + 12'(AUTO_DEADBAND)) < center12;
  assign auto_dn  = ball12 > (center12 + 12'(AUTO_DEADBAND));
  assign req_up   = pif.auto_mode ? auto_up : man_up;
  assign req_dn   = pif.auto_mode ? auto_dn : man_dn;
`else
  logic unused_auto;

  assign unused_auto = ^{pif.auto_mode, pif.ball_v_pos};
  assign req_up      = man_up;
  assign req_dn      = man_dn;
`endif

  // Staying in a move state: after ACCEL_FRAMES ticks at one speed, the next
  // held tick steps one faster and starts a new run at that speed.
  always_comb begin
    if (cnt_q == ACC_LAST) begin
      stay_cnt   = 8'd0;
      stay_speed = (speed_q >= MAX_SPD) ? MAX_SPD : speed_q + 4'd1;
    end else begin
      stay_cnt   = cnt_q + 8'd1;
      stay_speed = speed_q;
    end
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    step    = speed_q;
    do_up   = 1'b0;
    do_dn   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (req_up) begin
            state_d = UP;
            speed_d = 4'd1;
            cnt_d   = 8'd0;
            step    = 4'd1;
            do_up   = 1'b1;
          end else if (req_dn) begin
            state_d = DOWN;
            speed_d = 4'd1;
            cnt_d   = 8'd0;
            step    = 4'd1;
            do_dn   = 1'b1;
          end
        end
        UP: begin
          if (req_up) begin
            speed_d = stay_speed;
            cnt_d   = stay_cnt;
            step    = stay_speed;
            do_up   = 1'b1;
          end else if (req_dn) begin
            state_d = DOWN;
            speed_d = 4'd1;
            cnt_d   = 8'd0;
            step    = 4'd1;
            do_dn   = 1'b1;
          end else begin
            state_d = IDLE;
            speed_d = 4'd1;
            cnt_d   = 8'd0;
          end
        end
        DOWN: begin
          if (req_dn) begin
            speed_d = stay_speed;
            cnt_d   = stay_cnt;
            step    = stay_speed;
            do_dn   = 1'b1;
          end else if (req_up) begin
            state_d = UP;
            speed_d = 4'd1;
            cnt_d   = 8'd0;
            step    = 4'd1;
            do_up   = 1'b1;
          end else begin
            state_d = IDLE;
            speed_d = 4'd1;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = IDLE;
          speed_d = 4'd1;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // 12-bit arithmetic so neither the subtraction nor the bottom-edge sum wraps.
  assign pos12  = {1'b0, pos_q};
  assign step12 = {8'd0, step};
  assign up_pos = (pos12 < (TOP12 + step12)) ? 11'(TOP12) : 11'(pos12 - step12);
  assign dn_pos = ((pos12 + H12 + step12) > BOT12) ? 11'(BOT12 - H12) : 11'(pos12 + step12);

  always_comb begin
    pos_d = pos_q;
    if (do_up) begin
      pos_d = up_pos;
    end else if (do_dn) begin
      pos_d = dn_pos;
    end
  end

  // Half-open hit box from the currently registered position.
  always_comb begin
    pv_d = 1'b0;
    if (({1'b0, pif.vcount} >= pos12) && ({1'b0, pif.vcount} < (pos12 + H12)) &&
        ({1'b0, pif.hcount} >= {1'b0, pif.hpos}) &&
        ({1'b0, pif.hcount} < ({1'b0, pif.hpos} + W12))) begin
      pv_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      speed_q   <= 4'd1;
      cnt_q     <= 8'd0;
      pos_q     <= INIT11;
      vblank_q  <= 1'b0;
      vb_seen_q <= 1'b0;
      pv_q      <= 1'b0;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      vblank_q  <= pif.vblank;
      vb_seen_q <= 1'b1;
      pv_q      <= pv_d;
      moving_q  <= (state_d != IDLE);
    end
  end

  assign pif.paddle_v_pos = pos_q;
  assign pif.pixel_valid  = pv_q;
  assign pif.moving       = moving_q;
  assign pif.fsm_state    = state_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: constant vector tables, hand sequences for limits and
// reset, then random frames checked against a frame-level reference model.
module tb_paddle_ctrl;
  localparam int PADDLE_WIDTH  = 8;
  localparam int PADDLE_HEIGHT = 40;
  localparam int TOP_LIMIT     = 20;
  localparam int BOTTOM_LIMIT  = 460;
  localparam int INIT_POS      = 220;
  localparam int MAX_SPEED     = 8;
  localparam int ACCEL_FRAMES  = 4;
  localparam int AUTO_DEADBAND = 4;

  logic clk;
  logic rst;
  paddle_ctrl_if pif ();

  paddle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Direction 0 idle, 1 up, 2 down; run = ticks spent at the current speed.
  int m_pos, m_dir, m_speed, m_run;
  bit m_vb_prev;

  function automatic void model_reset();
    m_pos     = INIT_POS;
    m_dir     = 0;
    m_speed   = 1;
    m_run     = 0;
    m_vb_prev = 1'b1;
  endfunction

  function automatic void model_tick(bit ru, bit rd);
    int want;
    want = ru ? 1 : (rd ? 2 : 0);
    if (want == 0) begin
      m_dir   = 0;
      m_speed = 1;
      m_run   = 0;
      return;
    end
    if (want != m_dir) begin
      m_dir   = want;
      m_speed = 1;
      m_run   = 1;
    end else if (m_run == ACCEL_FRAMES) begin
      m_speed = (m_speed + 1 > MAX_SPEED) ? MAX_SPEED : m_speed + 1;
      m_run   = 1;
    end else begin
      m_run++;
    end
    if (m_dir == 1) m_pos = (m_pos - m_speed < TOP_LIMIT) ? TOP_LIMIT : m_pos - m_speed;
    else m_pos = (m_pos + m_speed > BOTTOM_LIMIT - PADDLE_HEIGHT) ? BOTTOM_LIMIT - PADDLE_HEIGHT
                                                                  : m_pos + m_speed;
  endfunction

  function automatic bit in_pad(int h, int v, int hp, int p);
    return (v >= p) && (v < p + PADDLE_HEIGHT) && (h >= hp) && (h < hp + PADDLE_WIDTH);
  endfunction

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];
  int n_vec;
  int n_err;

  task automatic check_val(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: predict {pos, moving, pixel_valid} for this edge, then compare.
  task automatic step();
    bit ru, rd, epv;
    logic [12:0] exp_v, got_v;
    ru = pif.up & ~pif.down;
    rd = pif.down & ~pif.up;
`ifdef PADDLE_AUTO_EN
    if (pif.auto_mode) begin
      ru = (int'(pif.ball_v_pos) + AUTO_DEADBAND) < (m_pos + PADDLE_HEIGHT / 2);
      rd = int'(pif.ball_v_pos) > (m_pos + PADDLE_HEIGHT / 2 + AUTO_DEADBAND);
    end
`endif
    epv = in_pad(int'(pif.hcount), int'(pif.vcount), int'(pif.hpos), m_pos);
    if (pif.vblank && !m_vb_prev) model_tick(ru, rd);
    m_vb_prev = pif.vblank;
    exp_q.push_back({11'(m_pos), (m_dir != 0), epv});
    @(posedge clk);
    #1;
    got_v = {pif.paddle_v_pos, pif.moving, pif.pixel_valid};
    exp_v = exp_q.pop_front();
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL step: pos/moving/pix got %0d/%0b/%0b expected %0d/%0b/%0b (t=%0t)",
               got_v[12:2], got_v[1], got_v[0], exp_v[12:2], exp_v[1], exp_v[0], $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(bit u, bit d);
    pif.up     = u;
    pif.down   = d;
    pif.vblank = 1'b1;
    step();
    pif.vblank = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_val("rst_pos", pif.paddle_v_pos, INIT_POS);
    check_val("rst_pix", pif.pixel_valid, 0);
    check_val("rst_moving", pif.moving, 0);
    check_val("rst_state", pif.fsm_state, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_pix();
    pif.hcount = 11'(int'(pif.hpos) + int'($urandom_range(0, 12)) - 2);
    pif.vcount = 11'(m_pos + int'($urandom_range(0, 46)) - 3);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    bit up;
    bit down;
    int exp_pos;
    bit exp_moving;
  } vec_t;

  vec_t tbl[11];
  int   top_seq[4];
  int   rev_seq[9];

  initial begin
    int p;
    for (int i = 0; i < 10; i++) begin
      tbl[i].up         = 1'b0;
      tbl[i].down       = 1'b1;
      tbl[i].exp_moving = 1'b1;
    end
    tbl[0].exp_pos = 221; tbl[1].exp_pos = 222; tbl[2].exp_pos = 223; tbl[3].exp_pos = 224;
    tbl[4].exp_pos = 226; tbl[5].exp_pos = 228; tbl[6].exp_pos = 230; tbl[7].exp_pos = 232;
    tbl[8].exp_pos = 235; tbl[9].exp_pos = 238;
    tbl[10] = '{up: 1'b0, down: 1'b0, exp_pos: 238, exp_moving: 1'b0};
    top_seq = '{21, 20, 20, 20};
    rev_seq = '{419, 418, 417, 416, 414, 412, 410, 408, 405};

    n_vec = 0;
    n_err = 0;
    pif.hcount     = '0;
    pif.vcount     = '0;
    pif.hpos       = 11'd16;
    pif.up         = 1'b0;
    pif.down       = 1'b0;
    pif.vblank     = 1'b0;
    pif.auto_mode  = 1'b0;
    pif.ball_v_pos = '0;
    do_reset();

    // Held request without a vblank edge does nothing.
    pif.up = 1'b1;
    repeat (5) step();
    check_val("no_tick_pos", pif.paddle_v_pos, 220);
    check_val("no_tick_moving", pif.moving, 0);

    // Acceleration table.
    for (int i = 0; i < 11; i++) begin
      pulse(tbl[i].up, tbl[i].down);
      check_val($sformatf("tbl%0d_pos", i), pif.paddle_v_pos, tbl[i].exp_pos);
      check_val($sformatf("tbl%0d_moving", i), pif.moving, tbl[i].exp_moving);
    end

    // Top clamp.
    for (int k = 0; k < 200 && m_pos != TOP_LIMIT; k++) pulse(1'b1, 1'b0);
    check_val("reach_top", pif.paddle_v_pos, 20);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check_val("top_prep", pif.paddle_v_pos, 22);
    pulse(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0);
      check_val($sformatf("top%0d_pos", i), pif.paddle_v_pos, top_seq[i]);
    end
    check_val("top_moving", pif.moving, 1);

    // Bottom clamp.
    for (int k = 0; k < 200 && m_pos != BOTTOM_LIMIT - PADDLE_HEIGHT; k++) pulse(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1);
      check_val($sformatf("bot%0d_pos", i), pif.paddle_v_pos, 420);
    end
    check_val("bot_moving", pif.moving, 1);

    // Both pressed, then ramp up to speed 3 and reverse.
    pulse(1'b1, 1'b1);
    check_val("both_pos", pif.paddle_v_pos, 420);
    check_val("both_moving", pif.moving, 0);
    for (int i = 0; i < 9; i++) begin
      pulse(1'b1, 1'b0);
      check_val($sformatf("rev%0d_pos", i), pif.paddle_v_pos, rev_seq[i]);
    end
    pulse(1'b0, 1'b1);
    check_val("reverse_pos", pif.paddle_v_pos, 406);
    pulse(1'b0, 1'b1);
    check_val("reverse_next", pif.paddle_v_pos, 407);
    pulse(1'b0, 1'b0);

    // Hit box scan around the paddle (pos 407, hpos 16).
    p = m_pos;
    for (int v = p - 2; v < p + 42; v++) begin
      for (int h = 13; h < 27; h++) begin
        pif.hcount = 11'(h);
        pif.vcount = 11'(v);
        step();
      end
    end
    pif.hcount = 11'd23; pif.vcount = 11'(p + 39); step();
    check_val("pix_corner_in", pif.pixel_valid, 1);
    pif.hcount = 11'd24; #1;
    check_val("pix_latency", pif.pixel_valid, 1);
    step();
    check_val("pix_h_edge", pif.pixel_valid, 0);
    pif.hcount = 11'd16; pif.vcount = 11'(p + 40); step();
    check_val("pix_v_edge", pif.pixel_valid, 0);
    pif.hcount = 11'd16; pif.vcount = 11'(p); step();
    check_val("pix_origin", pif.pixel_valid, 1);

    // Reset mid-frame, then vblank high through release.
    pif.vblank = 1'b1;
    pif.down   = 1'b1;
    pif.up     = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_val("midrst_pos", pif.paddle_v_pos, 220);
    check_val("midrst_moving", pif.moving, 0);
    check_val("midrst_pix", pif.pixel_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    check_val("vb_high_release", pif.paddle_v_pos, 220);
    pif.vblank = 1'b0;
    step();
    pif.vblank = 1'b1;
    step();
    check_val("fresh_edge", pif.paddle_v_pos, 221);
    pif.vblank = 1'b0;
    step();

    // Random frames against the model.
    for (int f = 0; f < 300; f++) begin
      int hi, lo;
      if ($urandom_range(0, 3) == 0) begin
        pif.up   = 1'($urandom_range(0, 1));
        pif.down = 1'($urandom_range(0, 1));
      end
`ifdef PADDLE_AUTO_EN
      pif.auto_mode  = 1'($urandom_range(0, 1));
      pif.ball_v_pos = 11'($urandom_range(0, 479));
`endif
      hi = int'($urandom_range(1, 3));
      lo = int'($urandom_range(1, 4));
      pif.vblank = 1'b1;
      for (int c = 0; c < hi; c++) begin
        rand_pix();
        step();
      end
      pif.vblank = 1'b0;
      for (int c = 0; c < lo; c++) begin
        rand_pix();
        step();
      end
    end

`ifdef PADDLE_AUTO_EN
    // Computer control: manual up is ignored, deadband holds still.
    pif.auto_mode = 1'b0;
    do_reset();
    pif.auto_mode  = 1'b1;
    pif.ball_v_pos = 11'd242;
    pulse(1'b1, 1'b0);
    check_val("auto_deadband_pos", pif.paddle_v_pos, 220);
    check_val("auto_deadband_moving", pif.moving, 0);
    pif.ball_v_pos = 11'd300;
    pulse(1'b1, 1'b0);
    check_val("auto_down_pos", pif.paddle_v_pos, 221);
    check_val("auto_down_moving", pif.moving, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
